// File: rtl/acc_demo_table_loader.sv
// acc_demo_table_loader: streams (W, X) table entries into the acc_demo table
// RAM, commits the entry count, and hands the committed table to the main scan.
// Each accepted entry becomes a one-cycle write one clock after its handshake.
// Overflow, descending X, and load requests during a scan are recorded as a
// sticky two-bit error code.
module acc_demo_table_loader #(
    parameter int unsigned MAX_ENTRIES = 1024,
    parameter int unsigned ORDER_CHECK = 1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_start_i,
    input  logic        entry_valid_i,
    output logic        entry_ready_o,
    input  logic [31:0] entry_wencode_i,
    input  logic [31:0] entry_xencode_i,
    input  logic        entry_last_i,
    input  logic        scan_req_i,
    input  logic        scan_done_i,
    output logic        acc_demo_wren_o,
    output logic [15:0] acc_demo_addr_o,
    output logic [31:0] acc_demo_Wencode_o,
    output logic [31:0] acc_demo_Xencode_o,
    output logic [15:0] acc_demo_particle_cnt_o,
    output logic        main_scan_start_o,
    output logic        table_valid_o,
    output logic        busy_o,
    output logic [1:0]  load_err_o
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned X_W    = 18;
    localparam int unsigned ERR_W  = 2;

    localparam logic [ADDR_W-1:0] MAX_CNT  = ADDR_W'(MAX_ENTRIES);
    localparam bit                ORDER_EN = (ORDER_CHECK != 0);

    localparam logic [ERR_W-1:0] ERR_NONE  = 2'd0;
    localparam logic [ERR_W-1:0] ERR_OVFL  = 2'd1;
    localparam logic [ERR_W-1:0] ERR_ORDER = 2'd2;
    localparam logic [ERR_W-1:0] ERR_SCAN  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_SCAN   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [X_W-1:0]      prev_x_q, prev_x_d;
    logic                ready_q, ready_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   xdata_q, xdata_d;
    logic [ADDR_W-1:0]   pcnt_q, pcnt_d;
    logic                scan_q, scan_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [ERR_W-1:0]    err_q, err_d;

    logic                handshake;
    logic                begin_load;
    logic [X_W-1:0]      entry_x;

    assign handshake = entry_valid_i & ready_q;
    assign entry_x   = entry_xencode_i[X_W-1:0];

    // Next-state and next-output logic for the loader FSM
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_x_d   = prev_x_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        xdata_d    = xdata_q;
        pcnt_d     = pcnt_q;
        scan_d     = scan_q;
        valid_d    = valid_q;
        err_d      = err_q;
        begin_load = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A load request beats a same-cycle scan request
                if (load_start_i) begin
                    begin_load = 1'b1;
                end else if (scan_req_i && valid_q) begin
                    state_d = ST_SCAN;
                    scan_d  = 1'b1;
                end
            end

            ST_LOAD: begin
                if (load_start_i) begin
                    // Restart: any entry offered this cycle is discarded
                    begin_load = 1'b1;
                end else if (handshake) begin
                    if (cnt_q == MAX_CNT) begin
                        err_d   = ERR_OVFL;
                        state_d = ST_ERR;
                    end else if (ORDER_EN && (entry_x < prev_x_q)) begin
                        err_d   = ERR_ORDER;
                        state_d = ST_ERR;
                    end else begin
                        wren_d   = 1'b1;
                        addr_d   = cnt_q;
                        wdata_d  = entry_wencode_i;
                        xdata_d  = entry_xencode_i;
                        cnt_d    = cnt_q + ADDR_W'(1);
                        prev_x_d = entry_x;
                        if (entry_last_i) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
            end

            ST_COMMIT: begin
                // cnt_q already includes the final entry
                pcnt_d  = cnt_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end

            ST_SCAN: begin
                if (load_start_i) begin
                    err_d = ERR_SCAN;
                end
                if (scan_done_i) begin
                    scan_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            ST_ERR: begin
                valid_d = 1'b0;
                if (load_start_i) begin
                    begin_load = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                scan_d  = 1'b0;
            end
        endcase

        // Common entry actions for a fresh or restarted load
        if (begin_load) begin
            state_d  = ST_LOAD;
            cnt_d    = '0;
            prev_x_d = '0;
            valid_d  = 1'b0;
            err_d    = ERR_NONE;
        end

        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs, cleared asynchronously by reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            prev_x_q <= '0;
            ready_q  <= 1'b0;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            xdata_q  <= '0;
            pcnt_q   <= '0;
            scan_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_x_q <= prev_x_d;
            ready_q  <= ready_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            xdata_q  <= xdata_d;
            pcnt_q   <= pcnt_d;
            scan_q   <= scan_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign entry_ready_o           = ready_q;
    assign acc_demo_wren_o         = wren_q;
    assign acc_demo_addr_o         = addr_q;
    assign acc_demo_Wencode_o      = wdata_q;
    assign acc_demo_Xencode_o      = xdata_q;
    assign acc_demo_particle_cnt_o = pcnt_q;
    assign main_scan_start_o       = scan_q;
    assign table_valid_o           = valid_q;
    assign busy_o                  = busy_q;
    assign load_err_o              = err_q;

endmodule

// File: tb/tb_acc_demo_table_loader.sv
// Bench for acc_demo_table_loader: a default-depth instance and a 4-entry
// instance share stimulus, with sel2 steering the control inputs to one of them.
module tb_acc_demo_table_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic ls, ev, sr, sd, last, sel2;
    logic [31:0] wenc, xenc;

    logic        rdy1, wr1, scan1, val1, busy1;
    logic [15:0] addr1, pc1;
    logic [31:0] w1, x1;
    logic [1:0]  err1;
    logic        rdy2, wr2, scan2, val2, busy2;
    logic [15:0] addr2, pc2;
    logic [31:0] w2, x2;
    logic [1:0]  err2;

    logic ls1, ev1, sr1, sd1, ls2, ev2, sr2, sd2;
    assign ls1 = ls & ~sel2;  assign ls2 = ls & sel2;
    assign ev1 = ev & ~sel2;  assign ev2 = ev & sel2;
    assign sr1 = sr & ~sel2;  assign sr2 = sr & sel2;
    assign sd1 = sd & ~sel2;  assign sd2 = sd & sel2;

    always #5 clk = ~clk;

    acc_demo_table_loader dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .load_start_i(ls1), .entry_valid_i(ev1),
        .entry_ready_o(rdy1), .entry_wencode_i(wenc), .entry_xencode_i(xenc),
        .entry_last_i(last), .scan_req_i(sr1), .scan_done_i(sd1),
        .acc_demo_wren_o(wr1), .acc_demo_addr_o(addr1), .acc_demo_Wencode_o(w1),
        .acc_demo_Xencode_o(x1), .acc_demo_particle_cnt_o(pc1),
        .main_scan_start_o(scan1), .table_valid_o(val1), .busy_o(busy1),
        .load_err_o(err1)
    );

    acc_demo_table_loader #(.MAX_ENTRIES(4), .ORDER_CHECK(1)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .load_start_i(ls2), .entry_valid_i(ev2),
        .entry_ready_o(rdy2), .entry_wencode_i(wenc), .entry_xencode_i(xenc),
        .entry_last_i(last), .scan_req_i(sr2), .scan_done_i(sd2),
        .acc_demo_wren_o(wr2), .acc_demo_addr_o(addr2), .acc_demo_Wencode_o(w2),
        .acc_demo_Xencode_o(x2), .acc_demo_particle_cnt_o(pc2),
        .main_scan_start_o(scan2), .table_valid_o(val2), .busy_o(busy2),
        .load_err_o(err2)
    );

    typedef struct {
        logic [31:0] w;
        logic [31:0] x;
        logic        last;
        logic        exp_wr;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] w;
        logic [31:0] x;
    } wr_t;

    vec_t vt[24];
    wr_t  q1[$];
    wr_t  q2[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_cnt1 = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int exp_addr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        wr_t e;
        if (wr1) begin
            wr_cnt1++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            if (q1.size() == 0) begin
                chk("dut1_unexpected_wr_addr", 32'(addr1), 32'hFFFF_FFFF);
            end else begin
                e = q1.pop_front();
                chk("dut1_wr_addr", 32'(addr1), 32'(e.addr));
                chk("dut1_wr_W", w1, e.w);
                chk("dut1_wr_X", x1, e.x);
            end
        end
        if (wr2) begin
            if (q2.size() == 0) begin
                chk("dut2_unexpected_wr_addr", 32'(addr2), 32'hFFFF_FFFF);
            end else begin
                e = q2.pop_front();
                chk("dut2_wr_addr", 32'(addr2), 32'(e.addr));
                chk("dut2_wr_W", w2, e.w);
                chk("dut2_wr_X", x2, e.x);
            end
        end
    end

    // which: 0 load_start, 1 scan_req, 2 scan_done, 3 load_start+scan_req
    task automatic pulse(input int which);
        @(posedge clk); #1;
        ls = (which == 0 || which == 3);
        sr = (which == 1 || which == 3);
        sd = (which == 2);
        if (ls) exp_addr = 0;
        @(posedge clk); #1;
        ls = 1'b0; sr = 1'b0; sd = 1'b0;
    endtask

    // Offer one entry; returns just after the handshake edge with valid still high
    task automatic send(input int idx);
        wr_t e;
        bit  ok;
        wenc = vt[idx].w;
        xenc = vt[idx].x;
        last = vt[idx].last;
        ev   = 1'b1;
        if (vt[idx].exp_wr) begin
            e.addr = 16'(exp_addr);
            e.w    = vt[idx].w;
            e.x    = vt[idx].x;
            if (sel2) q2.push_back(e); else q1.push_back(e);
            exp_addr++;
        end
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = sel2 ? rdy2 : rdy1;
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle_entry();
        ev = 1'b0; last = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 10 && (q1.size() != 0 || q2.size() != 0); t++) @(negedge clk);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: 0..10 ascending load, 11..13 order error,
        // 14..18 overflow on 4-deep, 19..22 exact-fill commit, 23 restart entry
        for (int i = 0; i < 11; i++) begin
            vt[i].w = 32'hA000_0000 + 32'(i * 7);
            vt[i].x = {14'(i + 1), 18'(i * 10)};
            vt[i].last = (i == 10);
            vt[i].exp_wr = 1'b1;
        end
        vt[11] = '{32'h1111_0001, 32'h0000_0005, 1'b0, 1'b1};
        vt[12] = '{32'h1111_0002, 32'hFFFC_000A, 1'b0, 1'b1};
        vt[13] = '{32'h1111_0003, 32'h0004_0007, 1'b1, 1'b0};
        vt[14] = '{32'h2222_0000, 32'h0000_0064, 1'b0, 1'b1};
        vt[15] = '{32'h2222_0001, 32'h3FFC_0064, 1'b0, 1'b1};
        vt[16] = '{32'h2222_0002, 32'h0000_0065, 1'b0, 1'b1};
        vt[17] = '{32'h2222_0003, 32'h0000_0066, 1'b0, 1'b1};
        vt[18] = '{32'h2222_0004, 32'h0000_0067, 1'b0, 1'b0};
        vt[19] = '{32'h3333_0000, 32'h0000_0001, 1'b0, 1'b1};
        vt[20] = '{32'h3333_0001, 32'h0000_0002, 1'b0, 1'b1};
        vt[21] = '{32'h3333_0002, 32'h0000_0003, 1'b0, 1'b1};
        vt[22] = '{32'h3333_0003, 32'h0000_0004, 1'b1, 1'b1};
        vt[23] = '{32'h4444_0000, 32'h0000_0003, 1'b1, 1'b1};

        rst_n = 1'b0; ls = 0; ev = 0; sr = 0; sd = 0; last = 0; sel2 = 0;
        wenc = '0; xenc = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_valid", 32'(val1), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_wren", 32'(wr1), 32'd0);
        chk("post_rst_err", 32'(err1), 32'd0);
        chk("post_rst_scan", 32'(scan1), 32'd0);
        chk("post_rst_pcnt", 32'(pc1), 32'd0);

        // 11-entry back-to-back load
        first_cyc = -1; wr_cnt1 = 0;
        pulse(0);
        chk("load_ready", 32'(rdy1), 32'd1);
        chk("load_busy", 32'(busy1), 32'd1);
        for (int i = 0; i < 11; i++) send(i);
        idle_entry();
        @(negedge clk);
        chk("commit_pcnt_unchanged", 32'(pc1), 32'd0);
        chk("commit_ready", 32'(rdy1), 32'd0);
        @(negedge clk);
        chk("pcnt_11", 32'(pc1), 32'd11);
        chk("valid_after_commit", 32'(val1), 32'd1);
        chk("idle_busy", 32'(busy1), 32'd0);
        chk("wr_count_11", 32'(wr_cnt1), 32'd11);
        chk("wr_span_10", 32'(last_cyc - first_cyc), 32'd10);
        drain();

        // Scan, load-during-scan error, done, rescan
        pulse(1);
        chk("scan_start_high", 32'(scan1), 32'd1);
        repeat (3) @(negedge clk);
        chk("scan_start_held", 32'(scan1), 32'd1);
        pulse(0);
        chk("scan_load_err3", 32'(err1), 32'd3);
        chk("scan_stays", 32'(scan1), 32'd1);
        chk("scan_no_ready", 32'(rdy1), 32'd0);
        pulse(2);
        chk("scan_done_low", 32'(scan1), 32'd0);
        chk("scan_done_valid", 32'(val1), 32'd1);
        chk("scan_done_idle", 32'(busy1), 32'd0);
        chk("err3_sticky", 32'(err1), 32'd3);
        pulse(1);
        chk("rescan_high", 32'(scan1), 32'd1);
        pulse(2);
        chk("rescan_low", 32'(scan1), 32'd0);

        // Same-cycle load and scan: load wins
        pulse(3);
        chk("tie_scan_low", 32'(scan1), 32'd0);
        chk("tie_in_load", 32'(rdy1), 32'd1);
        chk("tie_valid_cleared", 32'(val1), 32'd0);
        chk("tie_err_cleared", 32'(err1), 32'd0);

        // Order error: X = 5, 10, 7
        for (int i = 11; i < 14; i++) send(i);
        idle_entry();
        chk("order_err2", 32'(err1), 32'd2);
        chk("order_ready_low", 32'(rdy1), 32'd0);
        chk("order_valid_low", 32'(val1), 32'd0);
        chk("order_err_busy", 32'(busy1), 32'd1);
        drain();
        pulse(1);
        chk("err_scan_ignored", 32'(scan1), 32'd0);
        chk("err_state_kept", 32'(busy1), 32'd1);

        // 4-deep instance: overflow, then exact-fill commit
        sel2 = 1'b1;
        pulse(0);
        for (int i = 14; i < 19; i++) send(i);
        idle_entry();
        chk("ovfl_err1", 32'(err2), 32'd1);
        chk("ovfl_ready_low", 32'(rdy2), 32'd0);
        chk("ovfl_valid_low", 32'(val2), 32'd0);
        drain();
        pulse(0);
        for (int i = 19; i < 23; i++) send(i);
        idle_entry();
        repeat (2) @(negedge clk);
        chk("full_pcnt_4", 32'(pc2), 32'd4);
        chk("full_valid", 32'(val2), 32'd1);
        chk("full_err_none", 32'(err2), 32'd0);
        drain();
        sel2 = 1'b0;

        // Restart mid-load: address and previous X both cleared
        pulse(0);
        send(1); send(2);
        idle_entry();
        pulse(0);
        send(23);
        idle_entry();
        repeat (2) @(negedge clk);
        chk("restart_pcnt_1", 32'(pc1), 32'd1);
        chk("restart_valid", 32'(val1), 32'd1);
        chk("restart_err", 32'(err1), 32'd0);
        drain();

        // Asynchronous reset in the middle of a stream
        pulse(0);
        send(0);
        wenc = 32'hDEAD_BEEF; xenc = 32'h0000_0F00;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wren", 32'(wr1), 32'd0);
        chk("arst_addr", 32'(addr1), 32'd0);
        chk("arst_ready", 32'(rdy1), 32'd0);
        chk("arst_pcnt", 32'(pc1), 32'd0);
        chk("arst_busy", 32'(busy1), 32'd0);
        chk("arst_valid2", 32'(val2), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        wr_cnt1 = 0;
        repeat (5) @(negedge clk);
        chk("post_arst_no_wr", 32'(wr_cnt1), 32'd0);
        chk("post_arst_valid", 32'(val1), 32'd0);
        chk("post_arst_ready", 32'(rdy1), 32'd0);
        idle_entry();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acc_demo_table_loader.md
ACC_DEMO_TABLE_LOADER -- requirements
Module: acc_demo_table_loader

Interface
REQ-001 SHALL have parameter MAX_ENTRIES, default 1024, meaning the table depth in entries (≤65535).
REQ-002 SHALL have parameter ORDER_CHECK, default 1, which enables the ascending-X check.
REQ-003 clk_i  in  1  sole clock, 100 MHz.
REQ-004 rst_n_i  in  1  asynchronous, active-low reset.
REQ-005 load_start_i  in  1  one-cycle pulse that begins a table load.
REQ-006 entry_valid_i  in  1  entry stream valid.
REQ-007 entry_ready_o  out  1  entry stream ready.
REQ-008 entry_wencode_i  in  32  {extend[13:0], W[17:0]}.
REQ-009 entry_xencode_i  in  32  {extend[13:0], X[17:0]}.
REQ-010 entry_last_i  in  1  marks the final entry of the table.
REQ-011 scan_req_i  in  1  pulse that requests a main scan using the loaded table.
REQ-012 scan_done_i  in  1  pulse that signals the scan has ended.
REQ-013 acc_demo_wren_o  out  1  table write strobe.
REQ-014 acc_demo_addr_o  out  16  table write address.
REQ-015 acc_demo_Wencode_o / acc_demo_Xencode_o  out  32 each  table write data.
REQ-016 acc_demo_particle_cnt_o  out  16  number of valid entries, held stable.
REQ-017 main_scan_start_o  out  1  level; high while a scan runs.
REQ-018 table_valid_o  out  1  a committed table is present.
REQ-019 busy_o  out  1  state is not IDLE.
REQ-020 load_err_o  out  2  sticky error code: 0 none, 1 overflow, 2 X order, 3 load during scan.

Function
REQ-021 The block SHALL use states IDLE, LOAD, COMMIT, SCAN, ERR.
REQ-022 IDLE SHALL go to LOAD on load_start_i; on entering LOAD: address counter=0, table_valid_o=0, load_err_o=0, previous-X register=0.
REQ-023 In LOAD, entry_ready_o SHALL be 1 and the handshake is entry_valid_i&entry_ready_o; entry_ready_o SHALL be 0 in every other state.
REQ-024 Each handshake SHALL register the entry to the outputs with wren=1, addr=counter, data=entry, exactly one cycle after the handshake; the counter then increments.
REQ-025 acc_demo_wren_o SHALL be high for one cycle per accepted entry; back-to-back handshakes SHALL give consecutive writes with no gap.
REQ-026 A handshake with entry_last_i=1 SHALL transfer the state to COMMIT.
REQ-027 COMMIT SHALL last one cycle, set acc_demo_particle_cnt_o to the count of accepted entries (counter value after the last write), set table_valid_o=1, and return to IDLE.
REQ-028 A handshake when counter==MAX_ENTRIES SHALL not write, SHALL set load_err_o=1, and SHALL go to ERR.
REQ-029 With ORDER_CHECK=1, an entry whose X[17:0] is less than the previous accepted X[17:0] SHALL not write, SHALL set load_err_o=2, and SHALL go to ERR; equal X is legal.
REQ-030 ERR SHALL hold table_valid_o=0; it leaves only on load_start_i, which goes to LOAD.
REQ-031 IDLE SHALL go to SCAN on scan_req_i only when table_valid_o=1; otherwise the request is ignored.
REQ-032 main_scan_start_o SHALL rise one cycle after an accepted scan_req_i and SHALL stay 1 through SCAN.
REQ-033 SCAN SHALL go to IDLE on scan_done_i, with main_scan_start_o=0 the next cycle; table_valid_o SHALL stay 1 so the table can be rescanned.
REQ-034 load_start_i during SCAN SHALL be ignored for state purposes and SHALL set load_err_o=3.
REQ-035 If load_start_i and scan_req_i arrive in the same IDLE cycle, load_start_i SHALL win and scan_req_i SHALL be dropped.
REQ-036 load_start_i during LOAD SHALL restart the load: counter=0 and previous-X register=0.
REQ-037 acc_demo_particle_cnt_o SHALL change only in COMMIT.
REQ-038 A load that ends at exactly MAX_ENTRIES with last=1 SHALL commit normally.

Reset
REQ-039 On rst_n_i=0, immediately and independent of clk_i: state=IDLE, and all outputs = 0, counter=0.
REQ-040 Reset asserted mid-LOAD or mid-SCAN SHALL abort; after release, table_valid_o=0 and a new load_start_i is required.

Verification
REQ-041 Load 11 entries (addr 0..10, X ascending, last on the 11th) at one per cycle -> 11 consecutive wren pulses at addr 0..10 with data matching; particle_cnt_o=11; table_valid_o=1.
REQ-042 Load 3 entries with X=5,10,7 -> 2 writes; load_err_o=2; ERR state; table_valid_o=0; then a scan_req_i is ignored.
REQ-043 MAX_ENTRIES=4; load 5 entries with no last flag -> 4 writes; 5th not written; load_err_o=1.
REQ-044 Valid table; scan_req_i -> main_scan_start_o=1 the next cycle; load_start_i during SCAN -> load_err_o=3 and the state stays SCAN; scan_done_i -> main_scan_start_o=0 one cycle later.
REQ-045 Same-cycle load_start_i and scan_req_i in IDLE -> LOAD entered and main_scan_start_o stays 0.
REQ-046 Assert rst_n_i low mid-stream of entry_valid_i -> outputs 0 asynchronously; no wren after release until a new load.
